// File: rtl/mc_controller.sv
// mc_controller: RV32I multicycle control FSM with ALU/immediate decoders; MC_ILLEGAL_TRAP_EN adds a sticky ILLEGAL state.
module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] immsrc,
  output logic       regwrite,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
`ifdef MC_ILLEGAL_TRAP_EN
    , ILLEGAL = 4'd11
`endif
  } state_t;
  state_t cur, nxt;
  logic pcupdate, branch, mw, irw, rw;
  logic [1:0] aluop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= FETCH;
    else cur <= nxt;
  always_comb begin
    nxt = FETCH;
    pcupdate = 1'b0;
    branch = 1'b0;
    adrsrc = 1'b0;
    mw = 1'b0;
    irw = 1'b0;
    rw = 1'b0;
    resultsrc = 2'b00;
    alusrca = 2'b00;
    alusrcb = 2'b00;
    aluop = 2'b00;
    case (cur)
      FETCH: begin
        nxt = DECODE;
        irw = 1'b1;
        alusrcb = 2'b10;
        resultsrc = 2'b10;
        pcupdate = 1'b1;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011: nxt = EXECUTER;
          7'b0010011: nxt = EXECUTEI;
          7'b1100011: nxt = BEQ;
          7'b1101111: nxt = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default: nxt = ILLEGAL;
`else
          default: nxt = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        nxt = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD: begin
        nxt = MEMWB;
        adrsrc = 1'b1;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        rw = 1'b1;
      end
      MEMWRITE: begin
        adrsrc = 1'b1;
        mw = 1'b1;
      end
      EXECUTER: begin
        nxt = ALUWB;
        alusrca = 2'b10;
        aluop = 2'b10;
      end
      EXECUTEI: begin
        nxt = ALUWB;
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop = 2'b10;
      end
      ALUWB: rw = 1'b1;
      BEQ: begin
        alusrca = 2'b10;
        aluop = 2'b01;
        branch = 1'b1;
      end
      JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcupdate = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ILLEGAL: nxt = ILLEGAL;
`endif
      default: nxt = FETCH;
    endcase
  end
  // Write strobes are gated by rst_n so they drop the instant reset asserts.
  assign pcwrite  = rst_n & (pcupdate | (branch & zero));
  assign memwrite = rst_n & mw;
  assign irwrite  = rst_n & irw;
  assign regwrite = rst_n & rw;
  assign state    = cur;
  assign immsrc = (op == 7'b0100011) ? 2'b01 :
                  (op == 7'b1100011) ? 2'b10 :
                  (op == 7'b1101111) ? 2'b11 : 2'b00;
  assign alucontrol = (aluop == 2'b00) ? 3'b000 :
                      (aluop == 2'b01) ? 3'b001 :
                      (funct3 == 3'b000) ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                      (funct3 == 3'b010) ? 3'b101 :
                      (funct3 == 3'b110) ? 3'b011 :
                      (funct3 == 3'b111) ? 3'b010 : 3'b000;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed and random instruction streams checked against an instruction-level control model.
module tb_mc_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0;
  logic pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  int total = 0, bad = 0;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .immsrc(immsrc), .regwrite(regwrite), .state(state)
  );
  always #5 clk = ~clk;
  function automatic logic [19:0] got_vec();
    return {state, pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, alucontrol, immsrc, regwrite};
  endfunction
  function automatic logic [1:0] ref_imm(logic [6:0] o);
    return o == SW ? 2'b01 : o == BQ ? 2'b10 : o == JL ? 2'b11 : 2'b00;
  endfunction
  function automatic logic [2:0] ref_alu_exec(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'd0: return (o == RT && f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  // Expected outputs for one phase of the instruction: {state,pcw,adr,mw,irw,res,srca,srcb,aluc,imm,rw}
  function automatic logic [19:0] ref_vec(int st, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
    logic [1:0] res = 0, sa = 0, sb = 0;
    logic [2:0] ac = 0;
    case (st)
      0: begin irw = 1; pcw = 1; sb = 2; res = 2; end
      1: begin sa = 1; sb = 1; end
      2: begin sa = 2; sb = 1; end
      3: adr = 1;
      4: begin res = 1; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: begin sa = 2; ac = ref_alu_exec(o, f3, f7); end
      7: begin sa = 2; sb = 1; ac = ref_alu_exec(o, f3, f7); end
      8: rw = 1;
      9: begin sa = 2; ac = 3'b001; pcw = z; end
      10: begin sa = 1; sb = 2; pcw = 1; end
      default: ;
    endcase
    return {4'(st), pcw, adr, mw, irw, res, sa, sb, ac, ref_imm(o), rw};
  endfunction
  // Entry/exit: a little after the falling edge of a FETCH cycle.
  task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    int q[$];
    logic [19:0] want;
    case (o)
      LW: q = '{0, 1, 2, 3, 4};
      SW: q = '{0, 1, 2, 5};
      RT: q = '{0, 1, 6, 8};
      IT: q = '{0, 1, 7, 8};
      BQ: q = '{0, 1, 9};
      JL: q = '{0, 1, 10};
`ifdef MC_ILLEGAL_TRAP_EN
      default: q = '{0, 1, 11, 11, 11};
`else
      default: q = '{0, 1};
`endif
    endcase
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    foreach (q[i]) begin
      if (i > 0) @(negedge clk);
      #1;
      want = ref_vec(q[i], o, f3, f7, z);
      total++;
      if (got_vec() !== want) begin
        bad++;
        $display("FAIL %s step %0d: got %h want %h", name, i, got_vec(), want);
      end
    end
    @(negedge clk);
`ifdef MC_ILLEGAL_TRAP_EN
    if (q[q.size()-1] == 11) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
`endif
  endtask
  task automatic test_reset();
    total++;
    if ({state, pcwrite, irwrite, memwrite, regwrite, alusrcb, resultsrc} !== {4'd0, 4'b0, 2'b10, 2'b10}) begin
      bad++;
      $display("FAIL reset: got st=%0d pcw=%b irw=%b mw=%b rw=%b", state, pcwrite, irwrite, memwrite, regwrite);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset_midwrite();
    op = SW; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({state, memwrite} !== {4'd5, 1'b1}) begin
      bad++;
      $display("FAIL midwrite_pre: got st=%0d mw=%b want st=5 mw=1", state, memwrite);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({state, memwrite, pcwrite, irwrite} !== {4'd0, 3'b000}) begin
      bad++;
      $display("FAIL midwrite_rst: got st=%0d mw=%b pcw=%b irw=%b want 0 0 0 0", state, memwrite, pcwrite, irwrite);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({state, irwrite, pcwrite} !== {4'd0, 2'b11}) begin
      bad++;
      $display("FAIL midwrite_release: got st=%0d irw=%b pcw=%b want 0 1 1", state, irwrite, pcwrite);
    end
    @(negedge clk);
    #1;
    total++;
    if (state !== 4'd1) begin
      bad++;
      $display("FAIL midwrite_fetch: got st=%0d want 1", state);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_directed();
    run_instr("lw", LW, 3'd2, 1'b0, 1'b0);
    run_instr("sw", SW, 3'd2, 1'b0, 1'b1);
    run_instr("sub", RT, 3'd0, 1'b1, 1'b0);
    run_instr("add", RT, 3'd0, 1'b0, 1'b0);
    run_instr("slt", RT, 3'd2, 1'b0, 1'b0);
    run_instr("or", RT, 3'd6, 1'b0, 1'b0);
    run_instr("and", RT, 3'd7, 1'b0, 1'b0);
    run_instr("addi_f7", IT, 3'd0, 1'b1, 1'b0);
    run_instr("beq_taken", BQ, 3'd0, 1'b0, 1'b1);
    run_instr("beq_not", BQ, 3'd0, 1'b0, 1'b0);
    run_instr("jal", JL, 3'd0, 1'b0, 1'b0);
    run_instr("illegal0", 7'b0000000, 3'd0, 1'b0, 1'b0);
    run_instr("lw_after", LW, 3'd2, 1'b0, 1'b1);
  endtask
  task automatic test_random();
    logic [6:0] ops[10] = '{LW, SW, RT, IT, BQ, JL, 7'b0000000, 7'b1111111, 7'b0110111, 7'b0010111};
    for (int n = 0; n < 60; n++)
      run_instr("rand", ops[$urandom_range(0, 9)], 3'($urandom), 1'($urandom), 1'($urandom));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_reset_midwrite();
    test_directed();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
